// File: rtl/multi_ff_bank.sv
// Bank of WIDTH flip-flops whose per-bit behaviour (SR, JK, D, T) is picked each cycle by mode.
// Latency: one cycle from sampled inputs to q; qn is a combinational inverse of q.
// Backpressure: none; en=0 freezes q and the error state, err_clr is honoured regardless.
module multi_ff_bank #(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  mode_e            mode_sel;
  logic [WIDTH-1:0] sr_nxt;
  logic [WIDTH-1:0] jk_nxt;
  logic [WIDTH-1:0] d_nxt;
  logic [WIDTH-1:0] t_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             illegal;
  logic [CNT_W-1:0] cnt_inc;

  assign mode_sel = mode_e'(mode);

  // Per-mode next-state candidates; colliding SR bits (s=r=1) fall into the hold term.
  always_comb begin
    sr_nxt = (q & ~(r & ~s)) | (s & ~r);
    jk_nxt = (s & ~q) | (~r & q);
    d_nxt  = s;
    t_nxt  = q ^ s;
  end

  // Select the candidate for the active mode and flag SR collisions (one event per cycle).
  always_comb begin
    q_nxt   = q;
    illegal = 1'b0;
    case (mode_sel)
      MODE_SR: begin
        q_nxt   = sr_nxt;
        illegal = en && |(s & r);
      end
      MODE_JK: q_nxt = jk_nxt;
      MODE_D:  q_nxt = d_nxt;
      MODE_T:  q_nxt = t_nxt;
      default: q_nxt = q;
    endcase
  end

  // Saturating increment; a clear coinciding with a new event restarts the count at one.
  always_comb begin
    cnt_inc = err_cnt;
    if (err_clr)
      cnt_inc = CNT_ONE;
    else if (err_cnt != CNT_MAX)
      cnt_inc = err_cnt + CNT_ONE;
  end

  // Flip-flop state: reset dominates everything, then enable gates the update.
  always_ff @(posedge clk) begin
    if (rst)
      q <= RST_VAL;
    else if (en)
      q <= q_nxt;
  end

  // Sticky error flag and counter: a new illegal event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else if (illegal) begin
      err_flag <= 1'b1;
      err_cnt  <= cnt_inc;
    end else if (err_clr) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end
  end

  assign qn = ~q;

endmodule

// File: tb/tb_multi_ff_bank.sv
module tb_multi_ff_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] s = 8'h00;
  logic [7:0] r = 8'h00;
  logic       err_clr = 1'b0;
  logic [7:0] q;
  logic [7:0] qn;
  logic       err_flag;
  logic [3:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state derived directly from the behavioural rules.
  logic [7:0] exp_q = 8'h00;
  logic       exp_flag = 1'b0;
  int         exp_cnt = 0;

  multi_ff_bank #(.WIDTH(8), .CNT_W(4), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r),
    .err_clr(err_clr), .q(q), .qn(qn), .err_flag(err_flag), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Advance the model with the inputs about to be sampled, then cross one rising edge.
  task automatic tick();
    logic [7:0] nq;
    bit         ill;
    nq = exp_q;
    if (rst) begin
      exp_q = 8'h00; exp_flag = 1'b0; exp_cnt = 0;
    end else begin
      ill = en && mode == 2'b00 && (s & r) != 8'h00;
      if (en) begin
        for (int i = 0; i < 8; i++) begin
          case (mode)
            2'b00: begin
              if (s[i] && !r[i]) nq[i] = 1'b1;
              else if (!s[i] && r[i]) nq[i] = 1'b0;
            end
            2'b01: begin
              if (s[i] && !r[i]) nq[i] = 1'b1;
              else if (!s[i] && r[i]) nq[i] = 1'b0;
              else if (s[i] && r[i]) nq[i] = ~exp_q[i];
            end
            2'b10: nq[i] = s[i];
            default: if (s[i]) nq[i] = ~exp_q[i];
          endcase
        end
      end
      exp_q = nq;
      if (ill) begin
        exp_flag = 1'b1;
        exp_cnt = err_clr ? 1 : ((exp_cnt + 1 > 15) ? 15 : exp_cnt + 1);
      end else if (err_clr) begin
        exp_flag = 1'b0; exp_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 2'b11; s = 8'hFF; r = 8'hFF; err_clr = 1'b0;
    tick();
    rst = 1'b0; en = 1'b0;
    checks++;
    if (q !== 8'h00 || qn !== 8'hFF || err_flag !== 1'b0 || err_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset: q=%h qn=%h flag=%b cnt=%0d want q=00 qn=ff flag=0 cnt=0", q, qn, err_flag, err_cnt);
    end
  endtask

  task automatic test_sr_basic();
    en = 1'b1; mode = 2'b00; s = 8'hF0; r = 8'h00;
    tick();
    checks++;
    if (q !== 8'hF0) begin errors++; $display("FAIL sr_set: q=%h want f0", q); end
    s = 8'h00; r = 8'h30;
    tick();
    checks++;
    if (q !== 8'hC0 || qn !== 8'h3F) begin errors++; $display("FAIL sr_clr: q=%h qn=%h want c0 3f", q, qn); end
    s = 8'h00; r = 8'h00;
    tick();
    checks++;
    if (q !== 8'hC0 || err_flag !== 1'b0) begin errors++; $display("FAIL sr_hold: q=%h flag=%b want c0 0", q, err_flag); end
  endtask

  task automatic test_sr_illegal();
    s = 8'h81; r = 8'h80;
    tick();
    checks++;
    if (q !== 8'hC1 || err_flag !== 1'b1 || err_cnt !== 4'd1) begin
      errors++; $display("FAIL sr_illegal: q=%h flag=%b cnt=%0d want c1 1 1", q, err_flag, err_cnt);
    end
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (err_cnt !== 4'd15 || err_flag !== 1'b1 || q !== 8'hC1) begin
      errors++; $display("FAIL sr_saturate: cnt=%0d flag=%b q=%h want 15 1 c1", err_cnt, err_flag, q);
    end
  endtask

  task automatic test_jk_t();
    mode = 2'b10; s = 8'h0F; r = 8'h00; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (q !== 8'h0F || err_flag !== 1'b0 || err_cnt !== 4'd0) begin
      errors++; $display("FAIL clr_plain: q=%h flag=%b cnt=%0d want 0f 0 0", q, err_flag, err_cnt);
    end
    mode = 2'b01; s = 8'hFF; r = 8'hFF;
    tick();
    checks++;
    if (q !== 8'hF0 || err_flag !== 1'b0) begin errors++; $display("FAIL jk_toggle: q=%h flag=%b want f0 0", q, err_flag); end
    mode = 2'b11; s = 8'h11; r = 8'hFF;
    tick();
    checks++;
    if (q !== 8'hE1 || err_flag !== 1'b0) begin errors++; $display("FAIL t_toggle: q=%h flag=%b want e1 0", q, err_flag); end
  endtask

  task automatic test_d_enable();
    mode = 2'b10; s = 8'hA5; r = 8'h00;
    tick();
    checks++;
    if (q !== 8'hA5) begin errors++; $display("FAIL d_load: q=%h want a5", q); end
    en = 1'b0; s = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== 8'hA5) begin errors++; $display("FAIL en_hold%0d: q=%h want a5", i, q); end
    end
    // Illegal-looking inputs while disabled must not count.
    mode = 2'b00; s = 8'hFF; r = 8'hFF;
    tick();
    checks++;
    if (err_flag !== 1'b0 || err_cnt !== 4'd0 || q !== 8'hA5) begin
      errors++; $display("FAIL en_no_illegal: flag=%b cnt=%0d q=%h want 0 0 a5", err_flag, err_cnt, q);
    end
  endtask

  task automatic test_clear_collision();
    en = 1'b1; mode = 2'b00; s = 8'h01; r = 8'h01;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (err_cnt !== 4'd5) begin errors++; $display("FAIL cnt_five: cnt=%0d want 5", err_cnt); end
    err_clr = 1'b1;
    tick();
    checks++;
    if (err_flag !== 1'b1 || err_cnt !== 4'd1) begin
      errors++; $display("FAIL clr_collide: flag=%b cnt=%0d want 1 1", err_flag, err_cnt);
    end
    s = 8'h00; r = 8'h00;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_flag !== 1'b0 || err_cnt !== 4'd0) begin
      errors++; $display("FAIL clr_alone: flag=%b cnt=%0d want 0 0", err_flag, err_cnt);
    end
  endtask

  task automatic test_mid_reset();
    mode = 2'b10; s = 8'hFF; r = 8'h00;
    tick();
    mode = 2'b00; s = 8'hFF; r = 8'hFF;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (q !== 8'hFF || err_cnt !== 4'd7) begin errors++; $display("FAIL pre_reset: q=%h cnt=%0d want ff 7", q, err_cnt); end
    rst = 1'b1; mode = 2'b11; s = 8'hFF; err_clr = 1'b0;
    tick();
    rst = 1'b0;
    checks++;
    if (q !== 8'h00 || qn !== 8'hFF || err_flag !== 1'b0 || err_cnt !== 4'd0) begin
      errors++; $display("FAIL mid_reset: q=%h qn=%h flag=%b cnt=%0d want 00 ff 0 0", q, qn, err_flag, err_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 49) == 0);
      en      = ($urandom_range(0, 4) != 0);
      mode    = 2'($urandom_range(0, 3));
      s       = 8'($urandom);
      r       = 8'($urandom);
      // Keep collisions sparse enough that the counter spends time below saturation.
      if ($urandom_range(0, 2) != 0) r = r & ~s;
      err_clr = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if (q !== exp_q || qn !== ~exp_q || err_flag !== exp_flag || err_cnt !== 4'(exp_cnt)) begin
        errors++;
        $display("FAIL random%0d: q=%h qn=%h flag=%b cnt=%0d want q=%h flag=%b cnt=%0d",
                 n, q, qn, err_flag, err_cnt, exp_q, exp_flag, exp_cnt);
      end
    end
    rst = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sr_basic();
    test_sr_illegal();
    test_jk_t();
    test_d_enable();
    test_clear_collision();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_ff_bank.md
MULTI_FF_BANK -- requirements
Module: multi_ff_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of flip-flop bits.
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of the illegal-event counter.
REQ-003 The block SHALL have parameter RST_VAL, default {WIDTH{1'b0}}, giving the q value loaded on reset.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-006 The block SHALL have port en, input, 1 bit, the update enable.
REQ-007 The block SHALL have port mode, input, 2 bits, the flip-flop type: 00 SR, 01 JK, 10 D, 11 T.
REQ-008 The block SHALL have port s, input, WIDTH bits, the per-bit S, J, D or T input, depending on mode.
REQ-009 The block SHALL have port r, input, WIDTH bits, the per-bit R or K input; it is ignored in D and T modes.
REQ-010 The block SHALL have port err_clr, input, 1 bit, which clears err_flag and err_cnt.
REQ-011 The block SHALL have port q, output, WIDTH bits, the registered state.
REQ-012 The block SHALL have port qn, output, WIDTH bits, equal to ~q (combinational).
REQ-013 The block SHALL have port err_flag, output, 1 bit, a sticky illegal-input flag.
REQ-014 The block SHALL have port err_cnt, output, CNT_W bits, a saturating count of illegal cycles.

Function
REQ-015 Latency SHALL be one cycle: q reflects the inputs sampled at the rising edge immediately after the edge.
REQ-016 When en=0, q, err_flag and err_cnt SHALL hold their values; no illegal detection occurs. err_clr is still honoured.
REQ-017 In SR mode (en=1), each bit i SHALL update as follows:
- s=0, r=0: hold.
- s=1, r=0: set to 1.
- s=0, r=1: clear to 0.
- s=1, r=1: illegal; the bit holds.
REQ-018 In JK mode, each bit i SHALL update as follows: 00 hold, 10 set, 01 clear, 11 toggle. No illegal combination exists.
REQ-019 In D mode, q[i] SHALL take the value s[i].
REQ-020 In T mode, q[i] SHALL toggle when s[i]=1 and hold when s[i]=0.
REQ-021 An illegal cycle SHALL be any cycle with en=1, mode=SR and (s & r) != 0. Each such cycle counts once, regardless of how many bits collide.
REQ-022 On an illegal cycle, err_flag SHALL be set to 1 and err_cnt SHALL increment by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-023 When err_clr=1 and the cycle is not illegal, the next cycle SHALL give err_flag=0 and err_cnt=0.
REQ-024 When err_clr=1 coincides with an illegal cycle, the new event SHALL win: err_flag=1 and err_cnt=1.
REQ-025 Bits not involved in an illegal collision SHALL still update normally in that same cycle.
REQ-026 A mode change SHALL take effect on the cycle it is sampled, with no flush and no extra latency.

Reset
REQ-027 When rst=1 at a clock edge, the outputs SHALL become q=RST_VAL, qn=~RST_VAL, err_flag=0 and err_cnt=0.
REQ-028 Reset SHALL take priority over en, mode, s, r and err_clr, including in the middle of any sequence.
REQ-029 Before the first reset edge, the outputs SHALL be unspecified; the bench SHALL apply rst for at least one edge.

Verification (WIDTH=8, CNT_W=4, RST_VAL=0)
REQ-030 SR basic: mode=00, s=0xF0, r=0x00 -> q=0xF0. Then s=0x00, r=0x30 -> q=0xC0 and qn=0x3F. Then s=r=0 -> q holds at 0xC0.
REQ-031 SR illegal: from q=0xC0, apply s=0x81, r=0x80 -> q=0xC1, err_flag=1, err_cnt=1. Repeat 20 cycles -> err_cnt saturates at 15.
REQ-032 JK and T: with q=0x0F and mode=01, s=r=0xFF -> q=0xF0. Then mode=11, s=0x11 -> q=0xE1. Neither sets err_flag.
REQ-033 D and enable: mode=10, s=0xA5 -> q=0xA5. Then en=0, s=0x5A -> q stays 0xA5 for 3 cycles.
REQ-034 Clear collision: with err_cnt=5, assert err_clr together with an illegal SR cycle -> err_flag=1, err_cnt=1. Next cycle, err_clr alone -> err_flag=0, err_cnt=0.
REQ-035 Mid-operation reset: with q=0xFF and err_cnt=7, assert rst together with en=1, mode=11, s=0xFF -> q=0x00, err_flag=0, err_cnt=0.
